rice_core_pipeline_buffer: RTL



---
 rtl/rice_core_pkg.sv | 34 +++
 rtl/rice_core_wrap_counter.sv | 34 +++
 rtl/rice_core_pipeline_buffer.sv | 93 +++++++++
 3 files changed

// File: rtl/rice_core_pkg.sv
// Shared core types: pipeline-boundary result layouts and buffer limits.
package rice_core_pkg;

  localparam int RICE_CORE_BUFFER_MAX_DEPTH = 8;

  typedef enum logic [0:0] {
    STAGE_IF_ID = 1'b0,
    STAGE_ID_EX = 1'b1
  } rice_core_stage_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } rice_core_if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
  } rice_core_id_ex_t;

  // Stages size their boundary buffer WIDTH from this so both sides agree.
  function automatic int rice_core_stage_width(input rice_core_stage_e stage);
    case (stage)
      STAGE_IF_ID: return $bits(rice_core_if_id_t);
      STAGE_ID_EX: return $bits(rice_core_id_ex_t);
      default:     return 0;
    endcase
  endfunction

endpackage

// File: rtl/rice_core_wrap_counter.sv
// Modulo-DEPTH pointer with increment and synchronous clear.
module rice_core_wrap_counter #(
  parameter int DEPTH = 2,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic          i_incr,
  output logic [PW-1:0] o_ptr
);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (i_clear) begin
      ptr_d = '0;
    end else if (i_incr) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign o_ptr = ptr_q;

endmodule

// File: rtl/rice_core_pipeline_buffer.sv
// Elastic valid/ready buffer between two core pipeline stages; oldest entry
// is presented from storage registers, flush discards everything.
module rice_core_pipeline_buffer
  import rice_core_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 2,
  parameter bit READY_BYPASS = 1'b0,
  parameter int CW           = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_valid = !o_empty;
  assign o_count = count_q;

  // Bypass puts i_ready -> o_ready on a combinational path; the upstream
  // stage must budget for it.
  assign o_ready = READY_BYPASS ? (!o_full || i_ready) : !o_full;

  // Handshakes still complete during flush, but the data is dropped.
  assign push = i_valid && o_ready && !i_flush;
  assign pop  = o_valid && i_ready && !i_flush;

  rice_core_wrap_counter #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_flush),
    .i_incr  (push),
    .o_ptr   (wr_ptr)
  );

  rice_core_wrap_counter #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_flush),
    .i_incr  (pop),
    .o_ptr   (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (i_flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr] <= i_data;
    end
  end

  // Head is read straight out of storage registers: no i_data fall-through.
  assign o_data = mem_q[rd_ptr];

endmodule
